// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin sharing of one serial transmitter among
// NREQ byte requesters. One requester is granted in IDLE and its byte is
// latched. A single start pulse is issued, then the transmitter busy flag
// is followed through the frame, and priority rotates past the winner.
// Optional feature macro: SERIAL_TX_ARB_WDOG_EN (frame watchdog, sticky err).
module serial_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int DW          = 8,
    parameter int GW          = 2,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [DW-1:0]     tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [GW-1:0]     grant_id,
    output logic              active,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state, state_nx;
    logic [GW-1:0] ptr;
    logic [GW-1:0] pick;
    logic [GW-1:0] idx;
    logic          pick_ok;
    logic [DW-1:0] pick_data;
    logic          in_wait;
    logic          frame_done;
    logic          wdog_hit;

    assign in_wait    = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign frame_done = (state == WAIT_DONE) && !tx_busy;

    // Rotating-priority search: scan offsets high to low so the smallest
    // offset from ptr wins. NREQ is a power of two, so GW-bit adds wrap.
    always_comb begin
        pick    = ptr;
        pick_ok = 1'b0;
        idx     = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + GW'(i);
            if (req_valid[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    // Byte of the selected requester, muxed with constant slice offsets.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == GW'(i)) pick_data = req_data[i*DW +: DW];
        end
    end

`ifdef SERIAL_TX_ARB_WDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);

    logic [CW-1:0] wcnt;
    logic          err_q;

    // Fires on the edge that completes WDOG_CYCLES cycles spent waiting;
    // it overrides a normal completion on the same edge.
    assign wdog_hit = in_wait && (wcnt == CW'(WDOG_CYCLES - 1));
    assign err      = err_q;

    // Wait-cycle counter, cleared as the frame enters WAIT_BUSY; err is sticky.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            wcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ISSUE)  wcnt <= '0;
            else if (in_wait)    wcnt <= wcnt + 1'b1;
            if (wdog_hit)        err_q <= 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign err      = 1'b0;
`endif

    // State register.
    always_ff @(posedge m_clock) begin
        if (p_reset) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state and the ISSUE-cycle strobes; a busy line left high by a
    // foreign frame holds off arbitration in IDLE.
    always_comb begin
        state_nx  = state;
        tx_start  = 1'b0;
        req_ready = '0;
        case (state)
            IDLE:      if (!tx_busy && pick_ok) state_nx = ISSUE;
            ISSUE: begin
                tx_start  = 1'b1;
                req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
                state_nx  = WAIT_BUSY;
            end
            WAIT_BUSY: if (tx_busy) state_nx = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (wdog_hit) state_nx = IDLE;
    end

    // Grant latch and priority rotation; tx_data/grant_id hold between frames.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            tx_data  <= '0;
            grant_id <= '0;
            active   <= 1'b0;
            ptr      <= '0;
        end else begin
            if (state == IDLE && state_nx == ISSUE) begin
                tx_data  <= pick_data;
                grant_id <= pick;
                active   <= 1'b1;
            end
            if (frame_done || wdog_hit) begin
                active <= 1'b0;
                ptr    <= grant_id + GW'(1);
            end
        end
    end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one serial transmitter (the serial_s-style UART TX with start_send/busy) among NREQ byte requesters. It grants one requester and latches its byte. It pulses the transmitter start, tracks the transmitter busy flag until the frame completes, then rotates priority. It sits between the application byte sources and the TDX transmitter, in the m_clock domain.

Parameters:
NREQ, 4, number of requesters; legal values 2, 4, 8.
DW, 8, byte width per requester.
GW, 2, grant index width; must equal log2(NREQ).
WDOG_CYCLES, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
m_clock  in  1  system clock; all logic is rising-edge.
p_reset  in  1  synchronous, active-high reset.
req_valid  in  NREQ  per-requester byte-valid; must be held with data stable until the matching req_ready.
req_data  in  NREQ*DW  packed bytes; requester i uses bits [i*DW +: DW].
req_ready  out  NREQ  one-hot, one-cycle acceptance pulse.
tx_data  out  DW  byte presented to the transmitter; stable from tx_start until the frame ends.
tx_start  out  1  one-cycle start pulse to the transmitter (start_send).
tx_busy  in  1  transmitter busy; high for the whole frame.
grant_id  out  GW  index of the current or last granted requester.
active  out  1  high from grant until the frame completes.
err  out  1  watchdog error flag; tied 0 without the optional feature.

Behaviour:
- Reset (p_reset=1 at a clock edge): state IDLE. req_ready=0, tx_start=0, tx_data=0, grant_id=0, active=0, err=0, priority pointer ptr=0.
- Reset mid-frame: same reset values at the next edge. No start pulse is pending after reset.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid is set, select g = the first set bit searching ptr, ptr+1, ..., wrapping mod NREQ.
  - Register tx_data=req_data[g], grant_id=g, active=1, then go to ISSUE.
  - With no valid, stay in IDLE.
- ISSUE (exactly 1 cycle): tx_start=1 and req_ready[g]=1 in the same cycle, then go to WAIT_BUSY.
  - The requester may change its data or drop valid after this cycle.
- WAIT_BUSY: when tx_busy=1, go to WAIT_DONE. tx_start is low here.
- WAIT_DONE: when tx_busy=0, set active=0 and ptr=(g+1) mod NREQ, then go to IDLE.
- Latency: req_valid first sampled high at edge k -> tx_start and req_ready high in cycle k+1.
- Throughput: at most one byte per transmitter frame. There is at least one IDLE cycle between frames.
- req_valid changes during ISSUE, WAIT_BUSY and WAIT_DONE are ignored. Arbitration happens only in IDLE.
- Simultaneous requests: resolved by the rotating pointer. No requester waits more than NREQ-1 frames while holding valid.
- tx_busy high while in IDLE (a foreign or stale frame): IDLE does not arbitrate until tx_busy=0.
- tx_data and grant_id hold their values after the frame until the next grant.

Optional Feature:
Macro SERIAL_TX_ARB_WDOG_EN.
- Defined:
  - A counter clears on entry to WAIT_BUSY and counts each cycle spent in WAIT_BUSY or WAIT_DONE.
  - If it reaches WDOG_CYCLES, the block sets err=1 (sticky until p_reset), returns to IDLE with active=0, and advances ptr past g.
  - The accepted byte is dropped.
- Undefined: no counter; err is constant 0; WAIT states wait indefinitely.

Test Plan:
1. Reset: hold p_reset=1 for 5 clocks with req_valid=4'b1111 -> all outputs 0 and no tx_start. Release reset -> first grant goes to requester 0.
2. Single request: req_valid=4'b0100, req_data byte2=8'hA5 at edge k -> cycle k+1 has tx_start=1, req_ready=4'b0100, tx_data=8'hA5, grant_id=2. Model busy for 10 cycles -> active falls 1 cycle after busy falls.
3. Round-robin: hold req_valid=4'b1111 with bytes 8'h10/8'h11/8'h12/8'h13 -> transmit order 10,11,12,13,10. req_ready is one-hot once per frame.
4. Mid-frame request: requester 3 raises valid while requester 1 is in WAIT_DONE -> no grant until busy falls. Then grant_id=3 (ptr=2, with 2 idle).
5. Reset mid-frame: assert p_reset during WAIT_DONE -> next edge gives active=0, tx_start=0, ptr=0. The subsequent request from 0 is granted.
6. Watchdog (SERIAL_TX_ARB_WDOG_EN, WDOG_CYCLES=16): keep tx_busy=0 after tx_start -> err=1 exactly 16 cycles after entering WAIT_BUSY. The next request is still served. Without the macro, err stays 0 and active stays 1.
